// File: rtl/leg_pkg.sv
// Shared types and constants for the memory arbiter: requester indices, FSM state
// encoding and the round-robin pointer advance.
package leg_pkg;

  localparam int unsigned NREQ = 3;

  localparam logic [1:0] REQ_IFETCH = 2'd0;
  localparam logic [1:0] REQ_DATA   = 2'd1;
  localparam logic [1:0] REQ_DBG    = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_t;

  // Next round-robin start point; wraps debug back to ifetch.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == REQ_DBG) ? REQ_IFETCH : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search over three requesters, starting at ptr and
// wrapping 2 -> 0. grant is one-hot (or zero when nothing is valid).
module rr_picker
  import leg_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      idx
);

  logic [1:0] o0, o1, o2;

  always_comb begin
    case (ptr)
      2'd1:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd2:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase

    grant = '0;
    idx   = o0;
    if (valid[o0]) begin
      idx       = o0;
      grant[o0] = 1'b1;
    end else if (valid[o1]) begin
      idx       = o1;
      grant[o1] = 1'b1;
    end else if (valid[o2]) begin
      idx       = o2;
      grant[o2] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way round-robin arbiter in front of a single-port RAM with fixed read
// latency. One transaction in flight; responses go back to the owning requester.
module mem_arbiter
  import leg_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata
);

  arb_state_t        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;

  logic [NREQ-1:0]   pick_grant;
  logic [1:0]        pick_idx;

  rr_picker u_rr_picker (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rr_ptr_d  = rr_ptr_q;
    lat_cnt_d = lat_cnt_q;

    unique case (state_q)
      StIdle: begin
        // The latched copy only changes here, so it is stable for the whole transaction.
        if (|pick_grant) begin
          owner_d  = pick_idx;
          we_d     = req_we[pick_idx];
          addr_d   = req_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
          wdata_d  = req_wdata[32'(pick_idx) * DATA_W +: DATA_W];
          rr_ptr_d = rr_next(pick_idx);
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (RAM_LAT == 1) begin
          state_d = StResp;
        end else begin
          lat_cnt_d = 3'(RAM_LAT - 1);
          state_d   = StWait;
        end
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= REQ_IFETCH;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rr_ptr_q  <= REQ_IFETCH;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rr_ptr_q  <= rr_ptr_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  assign req_ready  = (state_q == StIdle) ? pick_grant : '0;
  assign ram_en     = (state_q == StIssue);
  assign ram_we     = ram_en & we_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  // RAM data lands exactly in the RESP cycle, so it is forwarded rather than registered.
  assign resp_rdata = (state_q == StResp && !we_q) ? ram_rdata : '0;

  always_comb begin
    resp_valid = '0;
    if (state_q == StResp) begin
      resp_valid[owner_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: two arbiters (RAM_LAT 1 and 3) each with a behavioural RAM;
// stimulus pushes expected responses, a negedge monitor pops and compares them.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid [2];
  logic [2:0]  req_we    [2];
  logic [2:0]  req_ready [2];
  logic [2:0]  resp_valid[2];
  logic [47:0] req_addr  [2];
  logic [47:0] req_wdata [2];
  logic [15:0] resp_rdata[2];
  logic [15:0] ram_addr  [2];
  logic [15:0] ram_wdata [2];
  logic [15:0] ram_rdata [2];
  logic        ram_en    [2];
  logic        ram_we    [2];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0]  owner;
    logic [15:0] rdata;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAMs: unwritten locations read a fixed pattern of the address.
  logic [15:0] mem     [2][256];
  logic        written [2][256];
  logic [15:0] pipe    [2][3];

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hDEAD : {8'hA5, a};
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int a = 0; a < 256; a++) written[d][a] <= 1'b0;
      end else if (ram_en[d] && ram_we[d]) begin
        mem[d][ram_addr[d][7:0]]     <= ram_wdata[d];
        written[d][ram_addr[d][7:0]] <= 1'b1;
      end
      if (ram_en[d] && !ram_we[d]) begin
        pipe[d][0] <= written[d][ram_addr[d][7:0]] ? mem[d][ram_addr[d][7:0]]
                                                   : init_val(ram_addr[d][7:0]);
      end else begin
        pipe[d][0] <= 16'h0;
      end
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end

  assign ram_rdata[0] = pipe[0][0];
  assign ram_rdata[1] = pipe[1][2];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic exp_t qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int qdue(input int d);
    return (d == 0) ? q0[0].due : q1[0].due;
  endfunction

  task automatic check(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int d);
    checks++;
    fails++;
    $display("FAIL %s dut%0d: got timeout expected completion", name, d);
  endtask

  // Monitor: every resp_valid must match the oldest expected entry, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (resp_valid[d] != 3'b000) begin
          if (qsize(d) == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp dut%0d: got resp_valid=%b expected none", d,
                     resp_valid[d]);
          end else begin
            e = qpop(d);
            check("resp_owner", d, 64'(resp_valid[d]), 64'(3'b001 << e.owner));
            check("resp_rdata", d, 64'(resp_rdata[d]), 64'(e.rdata));
            check("resp_cycle", d, 64'(cyc), 64'(e.due));
          end
        end else if (qsize(d) != 0 && qdue(d) < cyc) begin
          e = qpop(d);
          checks++;
          fails++;
          $display("FAIL missing_resp dut%0d: got none expected owner %0d at cycle %0d", d,
                   e.owner, e.due);
        end
      end
    end
  end

  task automatic wait_hs(input int d, input int r, output bit hs);
    int t;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < 50) begin
      @(negedge clk);
      t++;
      if (req_ready[d][r]) hs = 1'b1;
    end
    if (!hs) fail_now("grant_timeout", d);
  endtask

  task automatic do_req(input int d, input int r, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd);
    bit   hs;
    exp_t e;
    @(posedge clk);
    #1;
    req_valid[d][r]            = 1'b1;
    req_we[d][r]               = we;
    req_addr[d][r*16 +: 16]    = addr;
    req_wdata[d][r*16 +: 16]   = wdata;
    wait_hs(d, r, hs);
    if (hs) begin
      check("grant_onehot", d, 64'(req_ready[d]), 64'(3'b001 << r));
      e.owner = 2'(r);
      e.rdata = exp_rd;
      e.due   = cyc + 1 + lat(d);
      qpush(d, e);
    end
    @(posedge clk);
    #1;
    req_valid[d][r] = 1'b0;
    if (hs) begin
      @(negedge clk);
      check("ram_en_issue", d, 64'(ram_en[d]), 64'(1'b1));
      check("ram_we_issue", d, 64'(ram_we[d]), 64'(we));
      check("ram_addr_issue", d, 64'(ram_addr[d]), 64'(addr));
      check("ram_wdata_issue", d, 64'(ram_wdata[d]), 64'(wdata));
    end
  endtask

  // Hold mask valid until n grants; ord holds the expected grantee for grant k in bits 2k+:2.
  task automatic rr_run(input int d, input logic [2:0] mask, input int n,
                        input logic [11:0] ord);
    int         k;
    int         t;
    logic [1:0] r;
    exp_t       e;
    @(posedge clk);
    #1;
    req_addr[d]  = {16'h0032, 16'h0031, 16'h0030};
    req_we[d]    = 3'b000;
    req_valid[d] = mask;
    k = 0;
    t = 0;
    while (k < n && t < 200) begin
      @(negedge clk);
      t++;
      if (|(req_valid[d] & req_ready[d])) begin
        r = ord[2*k +: 2];
        check("rr_grant", d, 64'(req_ready[d]), 64'(3'b001 << r));
        e.owner = r;
        e.rdata = 16'hA530 + 16'(r);
        e.due   = cyc + 1 + lat(d);
        qpush(d, e);
        k++;
      end
    end
    if (k < n) fail_now("rr_timeout", d);
    @(posedge clk);
    #1;
    req_valid[d] = 3'b000;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qsize(0) != 0 || qsize(1) != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (qsize(0) != 0 || qsize(1) != 0) fail_now("drain_timeout", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog dut0: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      req_we[d]    = '0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ram_en", d, 64'(ram_en[d]), 64'(1'b0));
      check("rst_ram_we", d, 64'(ram_we[d]), 64'(1'b0));
      check("rst_resp_valid", d, 64'(resp_valid[d]), 64'(3'b000));
      check("rst_req_ready", d, 64'(req_ready[d]), 64'(3'b000));
      check("rst_resp_rdata", d, 64'(resp_rdata[d]), 64'(16'h0));
      check("rst_ram_addr", d, 64'(ram_addr[d]), 64'(16'h0));
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Ifetch read at latency 1.
    do_req(0, 0, 1'b0, 16'h0010, 16'h0000, 16'hDEAD);
    drain();

    // Data write then readback at latency 3; write responses carry zero data.
    do_req(1, 1, 1'b1, 16'h0020, 16'h0055, 16'h0000);
    drain();
    do_req(1, 1, 1'b0, 16'h0020, 16'h0000, 16'h0055);
    drain();

    // Debug pulses valid for one cycle while the FSM waits on the RAM.
    begin
      exp_t e;
      @(posedge clk);
      #1;
      req_valid[1][0]   = 1'b1;
      req_we[1][0]      = 1'b0;
      req_addr[1][15:0] = 16'h0020;
      wait_hs(1, 0, hs);
      if (hs) begin
        e.owner = 2'd0;
        e.rdata = 16'h0055;
        e.due   = cyc + 4;
        qpush(1, e);
      end
      @(posedge clk);
      #1 req_valid[1][0] = 1'b0;
      @(posedge clk);
      #1;
      req_valid[1][2]    = 1'b1;
      req_we[1][2]       = 1'b0;
      req_addr[1][47:32] = 16'h0040;
      @(negedge clk);
      check("dbg_ready_in_wait", 1, 64'(req_ready[1]), 64'(3'b000));
      @(posedge clk);
      #1 req_valid[1][2] = 1'b0;
      drain();
      repeat (6) @(negedge clk);
    end

    // Fresh reset, then all three requesters valid: rotation 0,1,2,0,1,2.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rr_run(0, 3'b111, 6, 12'h924);
    drain();

    // Reset during WAIT aborts silently; pointer restarts at ifetch afterwards.
    @(posedge clk);
    #1;
    req_valid[1][0]   = 1'b1;
    req_we[1][0]      = 1'b0;
    req_addr[1][15:0] = 16'h0030;
    wait_hs(1, 0, hs);
    @(posedge clk);
    #1 req_valid[1][0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_ram_en", 1, 64'(ram_en[1]), 64'(1'b0));
    check("abort_resp_valid", 1, 64'(resp_valid[1]), 64'(3'b000));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    rr_run(1, 3'b011, 2, 12'h004);
    drain();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
